pipe_stage_buffer: RTL and testbench

//  Parametrised inter-stage pipeline buffer for all stage boundaries (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_stage_buffer.sv | 104 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: valid/ready inter-stage register with optional skid entry, flush, ctrl masking
// and saturating stall/bubble counters.
module pipe_stage_buffer #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  typedef enum logic [1:0] {EMPTY, FULL, SKIDF} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic rdy_q, rdy_d, accept, consume;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
  assign out_valid_o  = state_q != EMPTY;
  assign out_data_o   = m_data_q;
  assign out_ctrl_o   = m_ctrl_q;
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
  // Without a skid entry the only room for a new beat is the slot being vacated this cycle.
  assign in_ready_o = rdy_q & ~flush_i & ((SKID != 0) | ~out_valid_o | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign consume    = out_valid_o & out_ready_i;
  assign rdy_d      = state_d != SKIDF;
  assign stall_d  = cnt_clr_i ? '0 :
                    (out_valid_o & ~out_ready_i & stall_q != CNT_MAX) ? stall_q + CNT_W'(1) : stall_q;
  assign bubble_d = cnt_clr_i ? '0 :
                    (~out_valid_o & bubble_q != CNT_MAX) ? bubble_q + CNT_W'(1) : bubble_q;
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush_i) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d  = FULL;
          m_data_d = in_data_i;
          m_ctrl_d = in_ctrl_i;
        end
        FULL: if (accept && consume) begin
          m_data_d = in_data_i;
          m_ctrl_d = in_ctrl_i;
        end else if (consume) begin
          state_d  = EMPTY;
          m_ctrl_d = '0;
        end else if (accept) begin
          state_d  = SKIDF;
          s_data_d = in_data_i;
          s_ctrl_d = in_ctrl_i;
        end
        SKIDF: if (consume) begin
          state_d  = FULL;
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          s_ctrl_d = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= EMPTY;
      rdy_q    <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: drives a SKID=1 and a SKID=0 buffer with shared stimulus and checks both
// against a queue-based model of occupancy, ordering and counters.
module tb_pipe_stage_buffer;
  typedef struct packed {logic [31:0] d; logic [7:0] c;} beat_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 1, out_ready = 0, cnt_clr = 0;
  logic [31:0] in_data = 0;
  logic [7:0] in_ctrl = 0;
  logic ir[2], ov[2];
  logic [31:0] od[2];
  logic [7:0] oc[2];
  logic [3:0] sc[2], bc[2];
  int checks = 0, errors = 0;
  beat_t sb[2][$];
  int stall_m[2], bub_m[2];
  bit alive[2];
  always #5 clk = ~clk;
  pipe_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_data_o(od[0]), .out_ctrl_o(oc[0]), .cnt_clr_i(cnt_clr), .stall_cnt_o(sc[0]),
    .bubble_cnt_o(bc[0]));
  pipe_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_data_o(od[1]), .out_ctrl_o(oc[1]), .cnt_clr_i(cnt_clr), .stall_cnt_o(sc[1]),
    .bubble_cnt_o(bc[1]));
  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s skid=%0d t=%0t got %0h want %0h", n, k, $time, a, e);
    end
  endtask
  // Model: each DUT holds an ordered list of beats; capacity 2 with a registered ready, or
  // capacity 1 that frees up when the head leaves. Evaluated mid-cycle for the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit irx;
      int n;
      if (reset) begin
        sb[k].delete();
        alive[k] = 0;
        stall_m[k] = 0;
        bub_m[k] = 0;
      end
      n = sb[k].size();
      irx = alive[k] && !flush && (k == 1 ? n < 2 : (n == 0 || out_ready));
      chk("in_ready", k, 32'(ir[k]), 32'(irx));
      chk("out_valid", k, 32'(ov[k]), 32'(n != 0));
      if (n != 0) begin
        chk("out_data", k, od[k], sb[k][0].d);
        chk("out_ctrl", k, 32'(oc[k]), 32'(sb[k][0].c));
      end else chk("bubble_ctrl", k, 32'(oc[k]), 0);
      chk("stall_cnt", k, 32'(sc[k]), stall_m[k]);
      chk("bubble_cnt", k, 32'(bc[k]), bub_m[k]);
      if (!reset) begin
        stall_m[k] = cnt_clr ? 0 : (n != 0 && !out_ready) ? (stall_m[k] < 15 ? stall_m[k] + 1 : 15) : stall_m[k];
        bub_m[k] = cnt_clr ? 0 : (n == 0) ? (bub_m[k] < 15 ? bub_m[k] + 1 : 15) : bub_m[k];
        if (n != 0 && out_ready) void'(sb[k].pop_front());
        if (in_valid && irx) sb[k].push_back({in_data, in_ctrl});
        if (flush) sb[k].delete();
        alive[k] = 1;
      end
    end
  end
  task automatic drive(input bit iv, input logic [31:0] d, input logic [7:0] c, input bit ordy,
                       input bit fl, input bit clr);
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; cnt_clr = clr;
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    in_valid = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("reset_data", k, od[k], 0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) drive(1, i, 8'(i + 1), 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 32'hAAAA, 8'hFF, 0, 0, 0);
    drive(1, 32'hBBBB, 8'hFF, 0, 0, 0);
    repeat (20) drive(0, 0, 0, 0, 0, 0);
    drive(1, 32'hCCCC, 8'hFF, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'hAAAA, 8'h5A, 0, 0, 0);
    drive(1, 32'hBBBB, 8'hA5, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 32'h100 + i, 8'(i), (i % 2) == 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        repeat ($urandom_range(1, 2)) drive(1, $urandom, 8'($urandom), 0, 0, 0);
        reset = 0;
      end
      drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
